// File: rtl/ibuffer_warp_queue_pkg.sv
// Shared constants and helpers for the per-warp instruction buffer.
// Warp count, index width, default sizes and one-hot decode.
package ibuffer_warp_queue_pkg;

    localparam int NUM_WARPS = 8;
    localparam int WARP_ID_W = 3;
    localparam int PW_DEF    = 64;
    localparam int DEPTH_DEF = 4;

    typedef logic [NUM_WARPS-1:0] warp_mask_t;
    typedef logic [WARP_ID_W-1:0] warp_id_t;

    function automatic warp_id_t onehot_to_idx(input warp_mask_t oh);
        warp_id_t idx;
        idx = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (oh[i]) begin
                idx = idx | WARP_ID_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ibuffer_warp_fifo.sv
// Single-warp circular FIFO with two ordered push lanes, one pop and flush.
// Space is judged after the pop; lane 1 is the first to be dropped.
module ibuffer_warp_fifo
    import ibuffer_warp_queue_pkg::*;
#(
    parameter int PW    = PW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push0,
    input  logic [PW-1:0]              data0,
    input  logic                       push1,
    input  logic [PW-1:0]              data1,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic [PW-1:0]              head,
    output logic                       drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PW-1:0]    mem_q [DEPTH];
    logic [PW-1:0]    mem_d [DEPTH];

    logic             pop_ok;
    logic             acc0;
    logic             acc1;
    logic [CNT_W-1:0] free;
    logic [PTR_W-1:0] wr1_ptr;

    // Accept pop/pushes against post-pop space; flush overrides everything.
    always_comb begin
        pop_ok  = pop && (count_q != '0) && !flush;
        free    = CNT_W'(DEPTH) - count_q + CNT_W'(pop_ok);
        acc0    = !flush && push0 && (free != '0);
        acc1    = !flush && push1 && (free > CNT_W'(acc0));
        drop    = !flush && ((push0 && !acc0) || (push1 && !acc1));
        wr1_ptr = tail_q + PTR_W'(acc0);
        mem_d   = mem_q;
        if (acc0) begin
            mem_d[tail_q] = data0;
        end
        if (acc1) begin
            mem_d[wr1_ptr] = data1;
        end
        head_d  = head_q + PTR_W'(pop_ok);
        tail_d  = tail_q + PTR_W'(acc0) + PTR_W'(acc1);
        count_d = count_q - CNT_W'(pop_ok)
                + CNT_W'(acc0) + CNT_W'(acc1);
        if (flush) begin
            head_d  = tail_q;
            tail_d  = tail_q;
            count_d = '0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Bundle storage; contents are meaningless while count is zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count = count_q;
    assign head  = mem_q[head_q];

endmodule

// File: rtl/ibuffer_warp_queue.sv
// Eight-warp instruction buffer between decode and issue.
// Demuxes both decode lanes, muxes the issue head, raises fetch requests.
module ibuffer_warp_queue
    import ibuffer_warp_queue_pkg::*;
#(
    parameter int PW    = PW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PW-1:0]        Data_ID0_IB,
    input  logic [PW-1:0]        Data_ID1_IB,
    input  logic [NUM_WARPS-1:0] Valid_ID0_IB,
    input  logic [NUM_WARPS-1:0] Valid_ID1_IB,
    input  logic [NUM_WARPS-1:0] Flush_SIMT_IB,
    input  logic                 Pop_Issue_IB,
    input  logic [WARP_ID_W-1:0] WarpID_Issue_IB,
    output logic [NUM_WARPS-1:0] Req_IB_PC,
    output logic [NUM_WARPS-1:0] Valid_IB_Issue,
    output logic [PW-1:0]        Head_IB_Issue,
    output logic                 Overflow_IB
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    warp_id_t         idx0;
    warp_id_t         idx1;
    warp_mask_t       push0;
    warp_mask_t       push1;
    warp_mask_t       drop;
    logic [CNT_W-1:0] cnt_w  [NUM_WARPS];
    logic [PW-1:0]    head_w [NUM_WARPS];
    logic             ovf_q, ovf_d;

    // Steer each lane's one-hot select to a single warp.
    always_comb begin
        idx0  = onehot_to_idx(Valid_ID0_IB);
        idx1  = onehot_to_idx(Valid_ID1_IB);
        push0 = '0;
        push1 = '0;
        if (|Valid_ID0_IB) begin
            push0[idx0] = 1'b1;
        end
        if (|Valid_ID1_IB) begin
            push1[idx1] = 1'b1;
        end
    end

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        ibuffer_warp_fifo #(
            .PW    (PW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push0 (push0[w]),
            .data0 (Data_ID0_IB),
            .push1 (push1[w]),
            .data1 (Data_ID1_IB),
            .pop   (Pop_Issue_IB && (WarpID_Issue_IB == WARP_ID_W'(w))),
            .flush (Flush_SIMT_IB[w]),
            .count (cnt_w[w]),
            .head  (head_w[w]),
            .drop  (drop[w])
        );

        // Leave room for three fetches already in flight.
        assign Req_IB_PC[w]      = cnt_w[w] <= CNT_W'(DEPTH - 3);
        assign Valid_IB_Issue[w] = cnt_w[w] != '0;
    end

    // Sticky overflow: any dropped push latches until reset.
    always_comb begin
        ovf_d = ovf_q | (|drop);
    end

    // Overflow register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign Head_IB_Issue = head_w[WarpID_Issue_IB];
    assign Overflow_IB   = ovf_q;

endmodule

// File: tb/tb_ibuffer_warp_queue.sv
// Scoreboard bench for ibuffer_warp_queue.
// Directed stimulus queues expectations; a negedge monitor checks them.
module tb_ibuffer_warp_queue;

    localparam int PW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] d0 = '0;
    logic [PW-1:0] d1 = '0;
    logic [7:0]    v0 = '0;
    logic [7:0]    v1 = '0;
    logic [7:0]    fl = '0;
    logic          pop = 1'b0;
    logic [2:0]    wid = '0;
    logic [7:0]    req;
    logic [7:0]    vld;
    logic [PW-1:0] head;
    logic          ovf;

    ibuffer_warp_queue #(.PW(PW), .DEPTH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .Data_ID0_IB     (d0),
        .Data_ID1_IB     (d1),
        .Valid_ID0_IB    (v0),
        .Valid_ID1_IB    (v1),
        .Flush_SIMT_IB   (fl),
        .Pop_Issue_IB    (pop),
        .WarpID_Issue_IB (wid),
        .Req_IB_PC       (req),
        .Valid_IB_Issue  (vld),
        .Head_IB_Issue   (head),
        .Overflow_IB     (ovf)
    );

    always #5 clk = ~clk;

    typedef enum int {K_VALID, K_REQ, K_HEAD, K_OVF} kind_e;
    typedef struct {
        string       name;
        kind_e       kind;
        logic [63:0] val;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [63:0] mon_act;
    int          checks = 0;
    int          errors = 0;

    task automatic push_exp(input kind_e k, input logic [63:0] v,
                            input string n);
        exp_t e;
        e.name = n;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic ex(input logic [7:0] ev, input logic [7:0] er,
                      input logic eo, input string n);
        push_exp(K_VALID, {56'b0, ev}, {n, "_valid"});
        push_exp(K_REQ, {56'b0, er}, {n, "_req"});
        push_exp(K_OVF, {63'b0, eo}, {n, "_ovf"});
    endtask

    task automatic eh(input logic [63:0] eval, input string n);
        push_exp(K_HEAD, eval, {n, "_head"});
    endtask

    task automatic drive(input logic [7:0] a0, input logic [63:0] x0,
                         input logic [7:0] a1, input logic [63:0] x1,
                         input logic p, input logic [2:0] w,
                         input logic [7:0] f);
        @(negedge clk);
        #1;
        v0  = a0;
        d0  = x0;
        v1  = a1;
        d1  = x1;
        pop = p;
        wid = w;
        fl  = f;
        @(posedge clk);
        #1;
        v0  = '0;
        v1  = '0;
        pop = 1'b0;
        fl  = '0;
    endtask

    // Monitor: compare every queued expectation against the outputs.
    always @(negedge clk) begin
        while (sb.size() != 0) begin
            mon_e = sb.pop_front();
            case (mon_e.kind)
                K_VALID: mon_act = {56'b0, vld};
                K_REQ:   mon_act = {56'b0, req};
                K_HEAD:  mon_act = head;
                default: mon_act = {63'b0, ovf};
            endcase
            checks++;
            if (mon_act !== mon_e.val) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h",
                         mon_e.name, mon_act, mon_e.val);
            end
        end
    end

    initial begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        ex(8'h00, 8'hFF, 1'b0, "reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        drive('0, '0, '0, '0, 1'b0, 3'd0, '0);
        ex(8'h00, 8'hFF, 1'b0, "idle");

        drive(8'h08, 64'hA, 8'h08, 64'hB, 1'b0, 3'd3, '0);
        ex(8'h08, 8'hF7, 1'b0, "w3_dual");
        eh(64'hA, "w3_first");
        drive('0, '0, '0, '0, 1'b1, 3'd3, '0);
        ex(8'h08, 8'hFF, 1'b0, "w3_pop1");
        eh(64'hB, "w3_second");
        drive('0, '0, '0, '0, 1'b1, 3'd3, '0);
        ex(8'h00, 8'hFF, 1'b0, "w3_empty");

        drive(8'h20, 64'h1, 8'h20, 64'h2, 1'b0, 3'd5, '0);
        ex(8'h20, 8'hDF, 1'b0, "w5_two");
        eh(64'h1, "w5_two");
        drive(8'h20, 64'h3, 8'h20, 64'h4, 1'b0, 3'd5, '0);
        ex(8'h20, 8'hDF, 1'b0, "w5_full");
        eh(64'h1, "w5_full");
        drive(8'h20, 64'hC, '0, '0, 1'b1, 3'd5, '0);
        ex(8'h20, 8'hDF, 1'b0, "w5_popush");
        eh(64'h2, "w5_popush");
        drive(8'h20, 64'hD, 8'h20, 64'hE, 1'b0, 3'd5, '0);
        ex(8'h20, 8'hDF, 1'b1, "w5_ovf");
        eh(64'h2, "w5_ovf");
        drive('0, '0, '0, '0, 1'b1, 3'd5, '0);
        ex(8'h20, 8'hDF, 1'b1, "w5_pop_a");
        eh(64'h3, "w5_pop_a");
        drive('0, '0, '0, '0, 1'b1, 3'd5, '0);
        ex(8'h20, 8'hDF, 1'b1, "w5_pop_b");
        eh(64'h4, "w5_pop_b");
        drive('0, '0, '0, '0, 1'b1, 3'd5, '0);
        ex(8'h20, 8'hFF, 1'b1, "w5_pop_c");
        eh(64'hC, "w5_last");
        drive('0, '0, '0, '0, 1'b1, 3'd5, '0);
        ex(8'h00, 8'hFF, 1'b1, "w5_drained");

        drive(8'h04, 64'h21, 8'h40, 64'h61, 1'b0, 3'd6, '0);
        ex(8'h44, 8'hFF, 1'b1, "w2w6");
        eh(64'h61, "w6_first");
        drive(8'h04, 64'h22, '0, '0, 1'b0, 3'd2, '0);
        ex(8'h44, 8'hFB, 1'b1, "w2_two");
        eh(64'h21, "w2_two");
        drive(8'h04, 64'h23, '0, '0, 1'b1, 3'd2, 8'h04);
        ex(8'h40, 8'hFF, 1'b1, "w2_flush");
        drive('0, '0, '0, '0, 1'b0, 3'd6, '0);
        ex(8'h40, 8'hFF, 1'b1, "post_flush");
        eh(64'h61, "w6_intact");
        drive(8'h04, 64'h24, '0, '0, 1'b0, 3'd2, '0);
        ex(8'h44, 8'hFF, 1'b1, "w2_refill");
        eh(64'h24, "w2_refill");

        for (int i = 0; i < 8; i++) begin
            drive(8'(1 << i), 64'h100 + 64'(i), '0, '0, 1'b0,
                  3'(i), '0);
        end
        ex(8'hFF, 8'hBB, 1'b1, "all_warps");
        eh(64'h107, "w7_head");

        @(negedge clk);
        #1;
        rst = 1'b1;
        v0  = 8'h01;
        d0  = 64'h999;
        wid = 3'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        v0  = '0;
        ex(8'h00, 8'hFF, 1'b0, "mid_reset");

        drive('0, '0, '0, '0, 1'b1, 3'd0, '0);
        ex(8'h00, 8'hFF, 1'b0, "pop_empty");

        drive(8'h01, 64'h55, '0, '0, 1'b0, 3'd0, '0);
        ex(8'h01, 8'hFF, 1'b0, "w0_one");
        eh(64'h55, "w0_one");
        drive('0, '0, 8'h01, 64'h56, 1'b0, 3'd0, '0);
        ex(8'h01, 8'hFE, 1'b0, "lane1_only");
        eh(64'h55, "lane1_only");
        drive(8'h01, 64'h57, '0, '0, 1'b0, 3'd0, '0);
        ex(8'h01, 8'hFE, 1'b0, "w0_three");
        drive(8'h01, 64'h58, 8'h01, 64'h59, 1'b0, 3'd0, '0);
        ex(8'h01, 8'hFE, 1'b1, "lane1_drop");
        eh(64'h55, "lane1_drop");
        drive('0, '0, '0, '0, 1'b1, 3'd0, '0);
        eh(64'h56, "w0_pop_a");
        drive('0, '0, '0, '0, 1'b1, 3'd0, '0);
        eh(64'h57, "w0_pop_b");
        drive('0, '0, '0, '0, 1'b1, 3'd0, '0);
        ex(8'h01, 8'hFF, 1'b1, "w0_pop_c");
        eh(64'h58, "w0_pop_c");
        drive('0, '0, '0, '0, 1'b1, 3'd0, '0);
        ex(8'h00, 8'hFF, 1'b1, "w0_drained");

        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0",
                     sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
